// File: rtl/microcode_store.sv
// Writable microcode store: power-up pattern sweep, pipelined synchronous read port,
// and a valid/ready streaming load port with an auto-incrementing write pointer.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_INIT | sweep writes pattern(cnt) to every word; ports ignored
//   ST_RUN  | reads accepted, load port ready
module microcode_store #(
    parameter int DATA_W    = 18,
    parameter int ADDR_W    = 10,
    parameter int INIT_MODE = 1,
    parameter int OUT_REG   = 0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_adr_i,
    output logic [DATA_W-1:0] rd_dat_o,
    output logic              rd_vld_o,
    input  logic              ld_adr_we_i,
    input  logic [ADDR_W-1:0] ld_adr_i,
    input  logic              ld_valid_i,
    input  logic [DATA_W-1:0] ld_dat_i,
    output logic              ld_ready_o,
    output logic [ADDR_W-1:0] ld_ptr_o,
    output logic              init_busy_o
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              init_busy_q, init_busy_d;
    logic              ld_ready_q, ld_ready_d;
    logic [ADDR_W-1:0] ld_ptr_q, ld_ptr_d;
    logic [DATA_W-1:0] rd1_dat_q, rd1_dat_d;
    logic              rd1_vld_q, rd1_vld_d;
    logic [DATA_W-1:0] rd2_dat_q, rd2_dat_d;
    logic              rd2_vld_q, rd2_vld_d;

    logic [DATA_W-1:0] addr_pat;
    logic [DATA_W-1:0] sweep_pat;
    logic              rd_acc;
    logic              ld_acc;
    logic              ptr_we;
    logic [ADDR_W-1:0] ld_wr_adr;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_wadr;
    logic [DATA_W-1:0] mem_wdat;

    generate
        if (DATA_W > ADDR_W) begin : g_pat_ext
            assign addr_pat = {{(DATA_W-ADDR_W){1'b0}}, cnt_q};
        end else begin : g_pat_trunc
            assign addr_pat = cnt_q[DATA_W-1:0];
        end
    endgenerate

    assign sweep_pat = (INIT_MODE != 0) ? addr_pat : '0;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        init_busy_d = init_busy_q;
        ld_ready_d  = ld_ready_q;
        ld_ptr_d    = ld_ptr_q;
        mem_we      = 1'b0;
        mem_wadr    = cnt_q;
        mem_wdat    = sweep_pat;

        // ld_ready_q is high exactly while in ST_RUN, so it gates both load paths
        rd_acc    = rd_en_i & (state_q == ST_RUN);
        ld_acc    = ld_valid_i & ld_ready_q;
        ptr_we    = ld_adr_we_i & ld_ready_q;
        ld_wr_adr = ptr_we ? ld_adr_i : ld_ptr_q;

        case (state_q)
            ST_INIT: begin
                mem_we = 1'b1;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == '1) begin
                    state_d     = ST_RUN;
                    init_busy_d = 1'b0;
                    ld_ready_d  = 1'b1;
                end
            end
            ST_RUN: begin
                if (ptr_we) begin
                    ld_ptr_d = ld_adr_i;
                end
                if (ld_acc) begin
                    mem_we   = 1'b1;
                    mem_wadr = ld_wr_adr;
                    mem_wdat = ld_dat_i;
                    ld_ptr_d = ld_wr_adr + 1'b1;
                end
            end
            default: state_d = ST_INIT;
        endcase

        // mem is sampled before this edge's write lands, giving read-first collisions
        rd1_vld_d = rd_acc;
        rd1_dat_d = rd_acc ? mem[rd_adr_i] : rd1_dat_q;
        rd2_vld_d = rd1_vld_q;
        rd2_dat_d = rd1_vld_q ? rd1_dat_q : rd2_dat_q;
    end

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem[mem_wadr] <= mem_wdat;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            init_busy_q <= 1'b1;
            ld_ready_q  <= 1'b0;
            ld_ptr_q    <= '0;
            rd1_dat_q   <= '0;
            rd1_vld_q   <= 1'b0;
            rd2_dat_q   <= '0;
            rd2_vld_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_busy_q <= init_busy_d;
            ld_ready_q  <= ld_ready_d;
            ld_ptr_q    <= ld_ptr_d;
            rd1_dat_q   <= rd1_dat_d;
            rd1_vld_q   <= rd1_vld_d;
            rd2_dat_q   <= rd2_dat_d;
            rd2_vld_q   <= rd2_vld_d;
        end
    end

    assign rd_dat_o    = (OUT_REG != 0) ? rd2_dat_q : rd1_dat_q;
    assign rd_vld_o    = (OUT_REG != 0) ? rd2_vld_q : rd1_vld_q;
    assign ld_ready_o  = ld_ready_q;
    assign ld_ptr_o    = ld_ptr_q;
    assign init_busy_o = init_busy_q;

endmodule
